// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge port.
//   mem_req  : fetch stage requests a word at mem_addr (held stable until ack)
//   mem_addr : request address
//   mem_ack  : memory returns mem_data this cycle (may arrive in the request cycle)
//   mem_data : instruction word, valid with mem_ack
// master = fetch stage, slave = instruction memory.
interface instruction_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_data);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage sitting right after the program counter.
// Issues one request per PC on the memory port, captures the returned word
// into the IF/ID register and pauses the PC until decode has taken it.
// Absorbs variable memory latency, decode stalls (one-entry skid buffer) and
// redirect flushes, including a flush while a request is still outstanding
// (the late ack is swallowed in DISCARD).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_InstructionFetch_PC/_PC_PLUS current PC and PC+4 from the PC stage
//   o_InstructionFetch_pause       hold the PC
//   i_InstructionFetch_stall       decode cannot accept
//   i_InstructionFetch_flush       redirect, discard fetch state
//   mem                            instruction memory port (master side)
//   o_InstructionFetch_valid/_instr/_PC/_PC_PLUS/_misalign  IF/ID register
//
// Optional feature: define IFETCH_ALIGN_CHECK_EN to suppress requests for
// PCs with PC[1:0]!=0 and deliver NOP_WORD flagged as misaligned instead.
module instruction_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  i_InstructionFetch_PC,
  input  logic [ADDR_W-1:0]  i_InstructionFetch_PC_PLUS,
  output logic               o_InstructionFetch_pause,
  input  logic               i_InstructionFetch_stall,
  input  logic               i_InstructionFetch_flush,
  instruction_fetch_if.master mem,
  output logic               o_InstructionFetch_valid,
  output logic [DATA_W-1:0]  o_InstructionFetch_instr,
  output logic [ADDR_W-1:0]  o_InstructionFetch_PC,
  output logic [ADDR_W-1:0]  o_InstructionFetch_PC_PLUS,
  output logic               o_InstructionFetch_misalign
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] disc_addr;   // address of the abandoned request

  // IF/ID register
  logic              valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_q, pcp_q;
  logic              mis_q;

  // skid buffer: word that arrived while decode was stalled
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc, skid_pcp;
  logic              skid_mis;

  logic              misaligned;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_data;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = (state == S_REQ) && (i_InstructionFetch_PC[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned PC completes immediately with a NOP and never reaches memory.
  assign fetch_ack  = misaligned | mem.mem_ack;
  assign fetch_data = misaligned ? NOP_WORD : mem.mem_data;

  always_comb begin
    mem.mem_req              = 1'b0;
    mem.mem_addr             = i_InstructionFetch_PC;
    o_InstructionFetch_pause = 1'b1;
    if (!rst) begin
      case (state)
        S_REQ: begin
          mem.mem_req              = !misaligned;
          o_InstructionFetch_pause = i_InstructionFetch_flush ? 1'b0
                                   : !(fetch_ack && !i_InstructionFetch_stall);
        end
        S_HOLD: begin
          o_InstructionFetch_pause = i_InstructionFetch_flush ? 1'b0
                                   : i_InstructionFetch_stall;
        end
        S_DISCARD: begin
          // keep the abandoned request stable until memory answers it
          mem.mem_req              = 1'b1;
          mem.mem_addr             = disc_addr;
          o_InstructionFetch_pause = !i_InstructionFetch_flush;
        end
        default: o_InstructionFetch_pause = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      disc_addr  <= '0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_WORD;
      pc_q       <= '0;
      pcp_q      <= '0;
      mis_q      <= 1'b0;
      skid_instr <= NOP_WORD;
      skid_pc    <= '0;
      skid_pcp   <= '0;
      skid_mis   <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (i_InstructionFetch_flush) begin
            valid_q   <= 1'b0;
            disc_addr <= i_InstructionFetch_PC;
            state     <= fetch_ack ? S_REQ : S_DISCARD;
          end else if (fetch_ack && !i_InstructionFetch_stall) begin
            valid_q <= 1'b1;
            instr_q <= fetch_data;
            pc_q    <= i_InstructionFetch_PC;
            pcp_q   <= i_InstructionFetch_PC_PLUS;
            mis_q   <= misaligned;
          end else if (fetch_ack) begin
            skid_instr <= fetch_data;
            skid_pc    <= i_InstructionFetch_PC;
            skid_pcp   <= i_InstructionFetch_PC_PLUS;
            skid_mis   <= misaligned;
            state      <= S_HOLD;
          end else if (!i_InstructionFetch_stall) begin
            valid_q <= 1'b0;   // bubble while memory is busy
          end
        end
        S_HOLD: begin
          if (i_InstructionFetch_flush) begin
            valid_q <= 1'b0;   // skid contents simply abandoned
            state   <= S_REQ;
          end else if (!i_InstructionFetch_stall) begin
            valid_q <= 1'b1;
            instr_q <= skid_instr;
            pc_q    <= skid_pc;
            pcp_q   <= skid_pcp;
            mis_q   <= skid_mis;
            state   <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (i_InstructionFetch_flush) valid_q <= 1'b0;
          if (mem.mem_ack) state <= S_REQ;   // stale word dropped
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign o_InstructionFetch_valid    = valid_q;
  assign o_InstructionFetch_instr    = valid_q ? instr_q : NOP_WORD;
  assign o_InstructionFetch_PC       = pc_q;
  assign o_InstructionFetch_PC_PLUS  = pcp_q;
  assign o_InstructionFetch_misalign = valid_q & mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc, pcp;
  logic        stall, flush;
  logic        pause, valid, mis;
  logic [31:0] instr, o_pc, o_pcp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(32), .DATA_W(32)) mem ();

  instruction_fetch #(.ADDR_W(32), .DATA_W(32), .NOP_WORD(NOP)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .i_InstructionFetch_PC       (pc),
    .i_InstructionFetch_PC_PLUS  (pcp),
    .o_InstructionFetch_pause    (pause),
    .i_InstructionFetch_stall    (stall),
    .i_InstructionFetch_flush    (flush),
    .mem                         (mem),
    .o_InstructionFetch_valid    (valid),
    .o_InstructionFetch_instr    (instr),
    .o_InstructionFetch_PC       (o_pc),
    .o_InstructionFetch_PC_PLUS  (o_pcp),
    .o_InstructionFetch_misalign (mis)
  );

  typedef struct {
    string       n;
    logic [31:0] pc;
    logic        stall, flush, ack;
    logic        e_pause, e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;

  // memory contents: distinct, nonzero word per address
  function automatic logic [31:0] W(input logic [31:0] a);
    return a ^ 32'h5A5A_F00D;
  endfunction

  function automatic vec_t V(input string n, input logic [31:0] p,
                             input logic s, input logic f, input logic a,
                             input logic ep, input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ei, input logic em);
    vec_t v;
    v.n = n; v.pc = p; v.stall = s; v.flush = f; v.ack = a;
    v.e_pause = ep; v.e_req = er; v.e_addr = ea;
    v.e_valid = ev; v.e_instr = ei; v.e_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    logic dut_load;
    sb_t  e;
    @(negedge clk);
    rst          = 1'b0;
    pc           = v.pc;
    pcp          = v.pc + 32'd4;
    stall        = v.stall;
    flush        = v.flush;
    mem.mem_ack  = v.ack;
    mem.mem_data = W(v.e_addr);
    #1;
    chk({v.n, " pause"}, 32'(pause), 32'(v.e_pause));
    chk({v.n, " mem_req"}, 32'(mem.mem_req), 32'(v.e_req));
    if (v.e_req) chk({v.n, " mem_addr"}, mem.mem_addr, v.e_addr);
    if (!v.e_pause && !v.flush) sbq.push_back('{instr: v.e_instr, pc: v.pc});
    dut_load = !pause && !flush;
    @(posedge clk);
    #1;
    chk({v.n, " valid"}, 32'(valid), 32'(v.e_valid));
    chk({v.n, " instr"}, instr, v.e_valid ? v.e_instr : NOP);
    chk({v.n, " misalign"}, 32'(mis), 32'(v.e_mis));
    if (dut_load) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s sb: unexpected IF/ID load instr %h pc %h", v.n, instr, o_pc);
      end else begin
        e = sbq.pop_front();
        chk({v.n, " sb_instr"}, instr, e.instr);
        chk({v.n, " sb_pc"}, o_pc, e.pc);
        chk({v.n, " sb_pc_plus"}, o_pcp, e.pc + 32'd4);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pc = 32'hABC; pcp = 32'hAC0; stall = 1'b0; flush = 1'b0;
    mem.mem_ack = 1'b1; mem.mem_data = 32'hDEAD_BEEF;

    // reset: registers cleared, port idle and PC held while rst is high
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    chk("rst pause", 32'(pause), 32'd1);
    chk("rst mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst instr", instr, NOP);
    chk("rst pc", o_pc, 32'd0);
    chk("rst pc_plus", o_pcp, 32'd0);
    chk("rst misalign", 32'(mis), 32'd0);

    //              name   pc             stl flu ack pau req addr           vld instr             mis
    // zero-wait memory: one instruction per cycle
    tbl.push_back(V("zw0", 32'h0,         0,  0,  1,  0,  1,  32'h0,         1,  W(32'h0),         0));
    tbl.push_back(V("zw4", 32'h4,         0,  0,  1,  0,  1,  32'h4,         1,  W(32'h4),         0));
    tbl.push_back(V("zw8", 32'h8,         0,  0,  1,  0,  1,  32'h8,         1,  W(32'h8),         0));
    // ack latency 3: pause 3 cycles, then low 1
    tbl.push_back(V("la0", 32'h100,       0,  0,  0,  1,  1,  32'h100,       0,  NOP,              0));
    tbl.push_back(V("la1", 32'h100,       0,  0,  0,  1,  1,  32'h100,       0,  NOP,              0));
    tbl.push_back(V("la2", 32'h100,       0,  0,  0,  1,  1,  32'h100,       0,  NOP,              0));
    tbl.push_back(V("la3", 32'h100,       0,  0,  1,  0,  1,  32'h100,       1,  W(32'h100),       0));
    // stall on ack: word skidded, delivered on release, no re-request of 0x8
    tbl.push_back(V("st0", 32'h8,         1,  0,  1,  1,  1,  32'h8,         1,  W(32'h100),       0));
    tbl.push_back(V("st1", 32'h8,         1,  0,  0,  1,  0,  32'h8,         1,  W(32'h100),       0));
    tbl.push_back(V("st2", 32'h8,         0,  0,  0,  0,  0,  32'h8,         1,  W(32'h8),         0));
    tbl.push_back(V("st3", 32'hC,         0,  0,  1,  0,  1,  32'hC,         1,  W(32'hC),         0));
    // flush with a request in flight: stale 0x20 word swallowed
    tbl.push_back(V("fl0", 32'h20,        0,  0,  0,  1,  1,  32'h20,        0,  NOP,              0));
    tbl.push_back(V("fl1", 32'h20,        0,  1,  0,  0,  1,  32'h20,        0,  NOP,              0));
    tbl.push_back(V("fl2", 32'h12345678,  0,  0,  0,  1,  1,  32'h20,        0,  NOP,              0));
    tbl.push_back(V("fl3", 32'h12345678,  0,  0,  1,  1,  1,  32'h20,        0,  NOP,              0));
    tbl.push_back(V("fl4", 32'h12345678,  0,  0,  0,  1,  1,  32'h12345678,  0,  NOP,              0));
    tbl.push_back(V("fl5", 32'h12345678,  0,  0,  1,  0,  1,  32'h12345678,  1,  W(32'h12345678),  0));
    // flush + stall while in HOLD: skid dropped
    tbl.push_back(V("hf0", 32'h200,       1,  0,  1,  1,  1,  32'h200,       1,  W(32'h12345678),  0));
    tbl.push_back(V("hf1", 32'h200,       1,  1,  0,  0,  0,  32'h200,       0,  NOP,              0));
    tbl.push_back(V("hf2", 32'h300,       0,  0,  1,  0,  1,  32'h300,       1,  W(32'h300),       0));
    // stall with no ack: IF/ID holds, request continues
    tbl.push_back(V("sn0", 32'h304,       1,  0,  0,  1,  1,  32'h304,       1,  W(32'h300),       0));
    tbl.push_back(V("sn1", 32'h304,       0,  0,  1,  0,  1,  32'h304,       1,  W(32'h304),       0));
    // misaligned PC
`ifdef IFETCH_ALIGN_CHECK_EN
    tbl.push_back(V("ma0", 32'h12345677,  0,  0,  0,  0,  0,  32'h12345677,  1,  NOP,              1));
`else
    tbl.push_back(V("ma0", 32'h12345677,  0,  0,  1,  0,  1,  32'h12345677,  1,  W(32'h12345677),  0));
`endif
    tbl.push_back(V("ma1", 32'h1234567C,  0,  0,  1,  0,  1,  32'h1234567C,  1,  W(32'h1234567C),  0));

    foreach (tbl[i]) run(tbl[i]);

    // hand-written: reset mid-request returns to REQ with cleared IF/ID
    @(negedge clk);
    rst = 1'b1; mem.mem_ack = 1'b0; stall = 1'b0; flush = 1'b0;
    #1;
    chk("rst2 pause", 32'(pause), 32'd1);
    chk("rst2 mem_req", 32'(mem.mem_req), 32'd0);
    @(posedge clk); #1;
    chk("rst2 valid", 32'(valid), 32'd0);
    chk("rst2 pc", o_pc, 32'd0);
    run(V("rr0", 32'h40, 0, 0, 1, 0, 1, 32'h40, 1, W(32'h40), 0));

    chk("sb empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of the program counter. Each cycle it takes the current PC and PC+4 and issues a request on a req/ack instruction-memory port. It captures the returned word into the IF/ID register and holds the PC (via pause) until the fetch has been accepted by decode. It absorbs variable memory latency, decode back-pressure, and redirect flushes, including a flush that arrives while a request is outstanding.

## Interface
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, instruction width
- NOP_WORD, 32'h00000000, instruction value driven when the output is invalid or misaligned
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_InstructionFetch_PC  in  ADDR_W  current PC from the program counter
- i_InstructionFetch_PC_PLUS  in  ADDR_W  PC+4 from the program counter
- o_InstructionFetch_pause  out  1  hold PC (drives the program counter's pause)
- i_InstructionFetch_stall  in  1  decode cannot accept a new instruction
- i_InstructionFetch_flush  in  1  redirect in progress; discard fetch state
- o_InstructionFetch_mem_req  out  1  memory request
- o_InstructionFetch_mem_addr  out  ADDR_W  request address (= i_InstructionFetch_PC)
- i_InstructionFetch_mem_ack  in  1  data valid this cycle; may arrive in the request cycle
- i_InstructionFetch_mem_data  in  DATA_W  instruction word, valid with ack
- o_InstructionFetch_valid  out  1  IF/ID holds a live instruction
- o_InstructionFetch_instr  out  DATA_W  IF/ID instruction
- o_InstructionFetch_PC  out  ADDR_W  IF/ID PC
- o_InstructionFetch_PC_PLUS  out  ADDR_W  IF/ID PC+4
- o_InstructionFetch_misalign  out  1  IF/ID instruction came from a misaligned PC

## Operation
- States: REQ, HOLD, DISCARD. Reset state is REQ.
- REQ:
  - mem_req=1, mem_addr=PC.
  - ack & !stall & !flush: IF/ID <= {1, data, PC, PC_PLUS}; pause=0 this cycle so PC advances; stay in REQ.
  - ack & stall & !flush: skid <= {data, PC, PC_PLUS}; IF/ID unchanged; pause=1; go to HOLD.
  - !ack & !flush: pause=1. If !stall, valid <= 0 (bubble). Otherwise IF/ID is held.
- HOLD:
  - mem_req=0, pause=1 while stall.
  - When stall falls: IF/ID <= {1, skid}, pause=0 for exactly that cycle, go to REQ.
- Flush (priority over stall and ack, any state):
  - valid <= 0 and the skid buffer is dropped.
  - pause=0 in the flush cycle so the PC can load the redirect.
  - If in REQ with no ack this cycle, go to DISCARD. Otherwise go to REQ.
- DISCARD:
  - mem_req=1, mem_addr held at the abandoned address, pause=1.
  - On ack, the data is dropped and the block goes to REQ; the next cycle requests the new PC.
  - A further flush while in DISCARD stays in DISCARD.
- mem_req and mem_addr are stable from assertion until ack.
- When valid=0, instr=NOP_WORD, misalign=0, and PC/PC_PLUS hold their last values.

## Timing
- Reset (rst high at an edge):
  - valid=0, instr=NOP_WORD, PC=0, PC_PLUS=0, misalign=0, state=REQ.
  - mem_req=0 and pause=1 combinationally while rst is high.
- Zero-wait memory (ack in the request cycle): one instruction per cycle. IF/ID is valid the edge after the request.
- N-cycle ack latency: pause is high for N cycles, then low for 1 cycle. IF/ID updates at the edge ending the ack cycle.
- pause is combinational from state, ack, stall, flush and rst.
- Stall with no ack in flight: IF/ID holds; the memory request continues.
- Stall lifted in HOLD: IF/ID is valid at the next edge; the next request is issued the cycle after.
- Reset mid-request: the outstanding ack is not tracked. Memory must be reset together with this block.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - In REQ, if PC[1:0]!=0, no memory request is issued (mem_req=0).
  - The block behaves as if it received an immediate ack with data NOP_WORD, and sets misalign=1 in IF/ID.
  - Stall and flush rules are unchanged.
- Macro undefined: no alignment check; mem_addr=PC unmodified; misalign is tied to 0.

## Test plan
- Reset, then zero-wait memory, PC 0,4,8 -> valid rises at the 1st edge after reset release; instr matches each word; pause stays 0 every cycle.
- Ack latency 3 at PC=0x100 -> pause=1 for 3 cycles then 0 for 1; IF/ID={1, word, 0x100, 0x104}; mem_addr stable at 0x100 throughout.
- Stall=1 asserted when ack arrives for PC=0x8, held for 2 cycles -> IF/ID keeps the old instruction; on stall release IF/ID gets the 0x8 word, pause=0 for that single cycle, no duplicate request to 0x8.
- Flush 1 cycle after a request to 0x20 with ack at +3, redirect PC=0x12345678 -> DISCARD, the 0x20 data is never valid; the next request goes to 0x12345678; valid=0 until its ack.
- Flush and stall in the same cycle while in HOLD -> skid dropped, valid=0, state REQ, pause=0 that cycle.
- With IFETCH_ALIGN_CHECK_EN, PC=0x12345677 -> mem_req=0; next edge valid=1, misalign=1, instr=NOP_WORD. Without the macro: a normal request to 0x12345677, misalign=0.
